block_find_min: RTL

//  Upstream stage of the RAM write path in the selection-sort datapath.
//  On i_start it scans RAM from i_start_addr up to NUM_ELEM-1 over a synchronous-read port.
//  It finds the unsigned minimum value and the address of that minimum.
//  It then presents the minimum as o_temp_min with a one-cycle o_wr_en / o_sel_wr request.

---
 rtl/block_find_min.sv | 101 ++++++++++
 1 files changed

// File: rtl/block_find_min.sv
// Scans RAM[i_start_addr..NUM_ELEM-1] and reports the unsigned minimum with its address. The done/write pulse arrives K+2 cycles after start.
// Starts are ignored while busy, and no request is queued; the RAM read port is assumed to be always ready.
module block_find_min #(
    parameter int SIZE_DATA = 8,
    parameter int SIZE_ADDR = 4,
    parameter int NUM_ELEM  = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic [SIZE_ADDR-1:0] i_start_addr,
    input  logic [SIZE_DATA-1:0] i_rd_data,
    output logic                 o_rd_en,
    output logic [SIZE_ADDR-1:0] o_rd_addr,
    output logic                 o_busy,
    output logic [SIZE_DATA-1:0] o_temp_min,
    output logic [SIZE_ADDR-1:0] o_min_addr,
    output logic                 o_wr_en,
    output logic                 o_sel_wr,
    output logic                 o_done
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

    localparam logic [SIZE_ADDR:0]   LP_NUM  = (SIZE_ADDR+1)'(NUM_ELEM);
    localparam logic [SIZE_ADDR-1:0] LP_LAST = SIZE_ADDR'(NUM_ELEM - 1);

    state_t               r_state, w_next;
    logic [SIZE_ADDR-1:0] r_cnt;
    logic [SIZE_ADDR-1:0] r_rd_addr_d;
    logic                 r_rd_vld;
    logic                 r_min_vld;
    logic [SIZE_DATA-1:0] r_min;
    logic [SIZE_ADDR-1:0] r_min_addr;
    logic                 w_start_ok;

    // Out-of-range start addresses are dropped, so the scan never reads past NUM_ELEM-1.
    assign w_start_ok = i_start && ({1'b0, i_start_addr} < LP_NUM);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start_ok) w_next = S_READ;
            S_READ:  if (r_cnt == LP_LAST) w_next = S_DRAIN;
            S_DRAIN: w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt       <= '0;
            r_rd_vld    <= 1'b0;
            r_rd_addr_d <= '0;
        end else begin
            if (r_state == S_IDLE && w_start_ok) begin
                r_cnt <= i_start_addr;
            end else if (r_state == S_READ && r_cnt != LP_LAST) begin
                r_cnt <= r_cnt + SIZE_ADDR'(1);
            end
            r_rd_vld    <= (r_state == S_READ);
            r_rd_addr_d <= r_cnt;
        end
    end

    // Strict less-than keeps the earliest address on ties.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_min_vld  <= 1'b0;
            r_min      <= '0;
            r_min_addr <= '0;
        end else if (r_state == S_IDLE && w_start_ok) begin
            r_min_vld <= 1'b0;
        end else if (r_rd_vld) begin
            r_min_vld <= 1'b1;
            if (!r_min_vld || i_rd_data < r_min) begin
                r_min      <= i_rd_data;
                r_min_addr <= r_rd_addr_d;
            end
        end
    end

    assign o_rd_en    = (r_state == S_READ);
    assign o_rd_addr  = r_cnt;
    assign o_busy     = (r_state != S_IDLE);
    assign o_temp_min = r_min;
    assign o_min_addr = r_min_addr;
    assign o_wr_en    = (r_state == S_DONE);
    assign o_sel_wr   = (r_state == S_DONE);
    assign o_done     = (r_state == S_DONE);

endmodule
